// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
//   Shared types and helpers for the multichannel PWM block.
//   - pwm_mode_e : counting mode latched at each period boundary
//   - pwm_dir_e  : center-mode counter direction
//   - pwm_max()  : full-scale count for a given resolution (2^width - 1)
//   - ch_idx_w() : width of a channel index, never less than one bit
// ----------------------------------------------------------------------------
package pwm_pkg;

    // Upper bound on channel count supported by the block.
    localparam int unsigned PWM_MAX_CHANNELS = 16;

    // Smallest legal channel-index width (a single channel still needs one bit).
    localparam int unsigned PWM_CH_IDX_MIN_W = 1;

    typedef enum logic {
        PWM_MODE_EDGE   = 1'b0,
        PWM_MODE_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    function automatic int unsigned pwm_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic int unsigned ch_idx_w(input int unsigned channels);
        if (channels <= 1)
            return PWM_CH_IDX_MIN_W;
        else
            return $clog2(channels);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// ----------------------------------------------------------------------------
// pwm_prescaler
//   Shared clock prescaler. Produces a single-cycle tick every 2^speed clocks
//   while enabled; held in reset (count cleared, no tick) while disabled.
// Ports
//   clk     in  1        clock
//   rst     in  1        asynchronous reset, active-high
//   enable  in  1        run/stop; low clears the prescale count
//   speed   in  PRESC_W  divide select, divide ratio = 2^speed
//   tick    out 1        combinational tick, one clk wide
// ----------------------------------------------------------------------------
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PRESC_W-1:0] speed,
    output logic               tick
);

    // Largest speed value is 2^PRESC_W-1, so the count must reach 2^(that)-1.
    localparam int PRE_W = (1 << PRESC_W) - 1;

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W:0]   term;

    // Terminal count for the current speed; one bit wider so the shift by the
    // maximum speed does not overflow before the subtraction.
    assign term = ((PRE_W+1)'(1) << speed) - (PRE_W+1)'(1);

    // '>=' rather than '==' so lowering speed while the count is already past
    // the new terminal value ticks on the next clock instead of wrapping.
    assign tick = enable && ({1'b0, pre_cnt} >= term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (!enable || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// ----------------------------------------------------------------------------
// pwm_multichannel
//   N-channel PWM generator with a shared prescaler and period counter.
//   Per-channel duty is double-buffered: writes land in a shadow register and
//   are copied to the active register only at a period boundary (or
//   continuously while disabled). Edge-aligned and center-aligned counting.
// Ports
//   clk           in  1          clock
//   rst           in  1          asynchronous reset, active-high
//   enable        in  1          run/stop; low holds counters, outputs low
//   speed         in  PRESC_W    prescale select, tick every 2^speed clk
//   center_mode   in  1          0 edge-aligned, 1 center-aligned (at boundary)
//   wr_en         in  1          duty write strobe
//   wr_ch         in  CH_W       channel index for the write
//   wr_duty       in  WIDTH      duty value for the shadow register
//   period_start  out 1          one-clk pulse when active duties/mode load
//   pwm           out CHANNELS   registered PWM outputs
// ----------------------------------------------------------------------------
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESC_W  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [PRESC_W-1:0]            speed,
    input  logic                          center_mode,
    input  logic                          wr_en,
    input  logic [ch_idx_w(CHANNELS)-1:0] wr_ch,
    input  logic [WIDTH-1:0]              wr_duty,
    output logic                          period_start,
    output logic [CHANNELS-1:0]           pwm
);

    localparam int CH_W = ch_idx_w(CHANNELS);

    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(pwm_max(WIDTH));
    localparam logic [WIDTH-1:0] CNT_TOP  = CNT_MAX - WIDTH'(1);   // last up-count value
    localparam logic [WIDTH-1:0] CNT_TURN = CNT_MAX - WIDTH'(2);   // first down-count value

    logic                tick;
    logic                boundary;
    logic [WIDTH-1:0]    cnt;
    pwm_dir_e            dir;
    pwm_mode_e           mode_q;
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];
    logic [CHANNELS-1:0] duty_hit;
    logic [CHANNELS-1:0] pwm_q;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .speed  (speed),
        .tick   (tick)
    );

    // A period starts on the tick taken at cnt==0 while counting up; in edge
    // mode dir never leaves DIR_UP so the direction term is always true there.
    assign boundary = tick && (cnt == '0) && (dir == DIR_UP);

    // ---- stage: period counter / direction / mode latch ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            mode_q       <= PWM_MODE_EDGE;
            period_start <= 1'b0;
        end else if (!enable) begin
            // Parked at a boundary so the first tick after enable starts a period.
            cnt          <= '0;
            dir          <= DIR_UP;
            mode_q       <= pwm_mode_e'(center_mode);
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (boundary) begin
                mode_q <= pwm_mode_e'(center_mode);
            end
            if (tick) begin
                // At the boundary cnt is 0, so the old mode_q still gives the
                // correct 0 -> 1 step regardless of the mode being loaded.
                if (mode_q == PWM_MODE_CENTER) begin
                    if (dir == DIR_UP) begin
                        if (cnt == CNT_TOP) begin
                            cnt <= CNT_TURN;
                            dir <= DIR_DOWN;
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end else begin
                        cnt <= cnt - WIDTH'(1);
                        if (cnt == WIDTH'(1)) begin
                            dir <= DIR_UP;
                        end
                    end
                end else begin
                    dir <= DIR_UP;
                    if (cnt == CNT_TOP) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
            end
        end
    end

    // ---- stage: shadow / active duty registers ----
    // Shadow writes and the shadow->active copy share an edge, so a write on
    // the boundary clock is seen by active only at the following boundary.
    // Indices at or above CHANNELS match no slot and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (wr_ch == CH_W'(i))) begin
                    shadow[i] <= wr_duty;
                end
                if (!enable || boundary) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // Per-channel compare; cnt never reaches CNT_MAX, so a full-scale duty
    // stays high for the whole period and a zero duty never goes high.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
        assign duty_hit[g] = (cnt < active[g]);
    end

    // ---- stage: registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
        end else if (!enable) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= duty_hit;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// ----------------------------------------------------------------------------
// tb_pwm_multichannel
//   Directed bench for pwm_multichannel (5 channels, 8-bit, 3-bit speed).
//   A period-position model predicts pwm/period_start every cycle; window
//   measurements between period_start pulses pin the model with literals.
// ----------------------------------------------------------------------------
module tb_pwm_multichannel;

    localparam int CH   = 5;
    localparam int W    = 8;
    localparam int PW   = 3;
    localparam int CHW  = 3;
    localparam int MAXV = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [PW-1:0] speed = '0;
    logic          center_mode = 1'b0;
    logic          wr_en = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [W-1:0]  wr_duty = '0;
    logic          period_start;
    logic [CH-1:0] pwm;

    always #5 clk = ~clk;

    pwm_multichannel #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .PRESC_W  (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .speed        (speed),
        .center_mode  (center_mode),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .period_start (period_start),
        .pwm          (pwm)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: position within the current period (in ticks since its
    // boundary) determines the counter value arithmetically.
    // ------------------------------------------------------------------
    int           m_sh [CH];
    int           m_act[CH];
    int           old_sh[CH];
    int           m_mode;
    int           m_pos;
    int           m_pre;
    logic [CH-1:0] m_pwm;
    logic         m_ps;
    bit           m_tick;
    int           m_c;

    function automatic int cnt_of(input int pos, input int mode);
        if (mode != 0)
            return (pos < MAXV) ? pos : 2 * (MAXV - 1) - pos;
        return pos;
    endfunction

    function automatic int per_of(input int mode);
        return (mode != 0) ? 2 * (MAXV - 1) : MAXV;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_sh[i]  = 0;
                m_act[i] = 0;
            end
            m_mode = 0; m_pos = 0; m_pre = 0; m_pwm = '0; m_ps = 1'b0;
        end else begin
            old_sh = m_sh;
            if (!enable) begin
                m_act = old_sh;
                m_mode = int'(center_mode);
                m_pos = 0; m_pre = 0; m_pwm = '0; m_ps = 1'b0;
            end else begin
                m_tick = (m_pre >= (1 << speed) - 1);
                m_pre  = m_tick ? 0 : m_pre + 1;
                m_c    = cnt_of(m_pos, m_mode);
                for (int i = 0; i < CH; i++) m_pwm[i] = (m_c < m_act[i]);
                m_ps = 1'b0;
                if (m_tick) begin
                    if (m_pos == 0) begin
                        m_act  = old_sh;
                        m_mode = int'(center_mode);
                        m_ps   = 1'b1;
                    end
                    m_pos = (m_pos + 1) % per_of(m_mode);
                end
            end
            if (wr_en && int'(wr_ch) < CH) m_sh[wr_ch] = int'(wr_duty);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("pwm_vs_model", 32'(pwm), 32'(m_pwm));
            check("period_start_vs_model", 32'(period_start), 32'(m_ps));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called on a negative edge)
    // ------------------------------------------------------------------
    int w_len;
    int w_hi[CH];

    task automatic wr(input int ch, input int duty);
        wr_en = 1'b1; wr_ch = CHW'(ch); wr_duty = W'(duty);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_ps(input int limit);
        int k = 0;
        while (period_start !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("period_start_seen", 32'(period_start), 32'd1);
    endtask

    // Counts pwm highs from the current period_start cycle up to (not
    // including) the next one.
    task automatic measure();
        w_len = 0;
        for (int i = 0; i < CH; i++) w_hi[i] = 0;
        do begin
            for (int i = 0; i < CH; i++) if (pwm[i] === 1'b1) w_hi[i]++;
            w_len++;
            @(negedge clk);
        end while (period_start !== 1'b1 && w_len < 6000);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("reset_pwm", 32'(pwm), 32'd0);
        check("reset_period_start", 32'(period_start), 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Load duties while disabled; channel index 5 does not exist.
        wr(0, 64); wr(1, 0); wr(2, 255); wr(3, 100); wr(4, 50); wr(5, 200);
        enable = 1'b1;
        wait_ps(400);

        // Edge mode, speed 0: 255-clk period, duty counts equal duty values.
        measure();
        check("edge_len", w_len, 255);
        check("edge_ch0_64", w_hi[0], 64);
        check("edge_ch1_zero", w_hi[1], 0);
        check("edge_ch2_full", w_hi[2], 255);
        check("edge_ch3_100", w_hi[3], 100);
        check("edge_ch4_ignored_wr", w_hi[4], 50);
        measure();
        check("edge_len2", w_len, 255);

        // Two writes inside one period: old duty holds, last write wins next.
        fork
            measure();
            begin wr(0, 10); wr(0, 200); end
        join
        check("dbl_wr_old_duty", w_hi[0], 64);
        measure();
        // cnt 0 still compares against the outgoing duty (64) -> high, then 1..199.
        check("dbl_wr_new_duty", w_hi[0], 200);

        // Write landing on the boundary clock: applies one period later.
        fork
            measure();
            begin repeat (254) @(negedge clk); wr(0, 30); end
        join
        check("bnd_wr_cur", w_hi[0], 200);
        measure();
        check("bnd_wr_next_old", w_hi[0], 200);
        measure();
        check("bnd_wr_applied", w_hi[0], 30);

        // Center mode, speed 2: 508 ticks * 4 clk. cnt 0 appears once per
        // period, so duty d is high for 2*d-1 ticks.
        speed = 3'd2;
        center_mode = 1'b1;
        @(negedge clk);
        wait_ps(3000);
        measure();
        check("ctr_len", w_len, 2032);
        check("ctr_ch0_30", w_hi[0], (2 * 30 - 1) * 4);
        check("ctr_ch1_zero", w_hi[1], 0);
        check("ctr_ch2_full", w_hi[2], 2032);
        check("ctr_ch3_100", w_hi[3], (2 * 100 - 1) * 4);
        check("ctr_ch4_50", w_hi[4], (2 * 50 - 1) * 4);
        measure();
        check("ctr_len2", w_len, 2032);

        // Disable mid-period, then re-enable.
        repeat (300) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("disable_pwm", 32'(pwm), 32'd0);
        check("disable_ps", 32'(period_start), 32'd0);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (period_start !== 1'b1 && k < 20);
        check("reenable_first_tick", k, 4);

        // Asynchronous reset between clock edges.
        repeat (20) @(negedge clk);
        check("pre_rst_ch2_high", 32'(pwm[2]), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm), 32'd0);
        check("async_rst_ps", 32'(period_start), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        check("shadow_lost_pwm", 32'(pwm), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
